// File: rtl/bomber_pkg.sv
// bomber_pkg
// Shared types and defaults for the Bomberman player controller.
//   command_t : per-frame command from the input decoder
//   pstate_t  : player FSM state as seen on the state output
//   dir_t     : glide direction latched when a move starts
//   tile_to_px: converts a tile index into the pixel coordinate of its top-left corner
package bomber_pkg;

    typedef enum logic [2:0] {
        CMD_UP       = 3'd0,
        CMD_DOWN     = 3'd1,
        CMD_LEFT     = 3'd2,
        CMD_RIGHT    = 3'd3,
        CMD_SET_BOMB = 3'd4,
        CMD_NO_OP    = 3'd5
    } command_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DEAD = 2'd2
    } pstate_t;

    // Encoded to match the low two bits of the direction commands.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int TILE_W_DEF = 64;
    localparam int TILE_H_DEF = 48;
    localparam int MAP_W_DEF  = 10;
    localparam int MAP_H_DEF  = 10;

    function automatic logic [9:0] tile_to_px(input logic [3:0] tile, input int tile_size);
        return 10'(int'(tile) * tile_size);
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// player_ctrl_if
// Bomb placement handshake between a player controller and the bomb manager.
//   bomb_req   : placement request, held until bomb_ack
//   bomb_tx/ty : tile of the requested bomb
//   bomb_power : blast radius of the requested bomb
//   bomb_ack   : bomb manager accepted the request
// master = player controller, slave = bomb manager.
interface player_ctrl_if;

    logic       bomb_req;
    logic [3:0] bomb_tx;
    logic [3:0] bomb_ty;
    logic [3:0] bomb_power;
    logic       bomb_ack;

    modport master (
        output bomb_req,
        output bomb_tx,
        output bomb_ty,
        output bomb_power,
        input  bomb_ack
    );

    modport slave (
        input  bomb_req,
        input  bomb_tx,
        input  bomb_ty,
        input  bomb_power,
        output bomb_ack
    );

endinterface

// File: rtl/player_ctrl_stats.sv
// player_stats
// Bomb inventory and blast power counters for one player.
//   clk, rst_n  : frame clock, asynchronous active-low reset
//   take        : accepted bomb request (inventory -1)
//   done        : one of this player's bombs exploded (inventory +1)
//   pu_bomb     : bomb-count power-up (inventory +1)
//   pu_power    : blast-power power-up (power +1)
//   respawn     : reload both counters with their initial values
//   bombs_left  : bombs currently available, saturates at MAX_BOMBS
//   power       : blast radius, saturates at MAX_POWER
module player_stats #(
    parameter int BOMBS_INIT = 1,
    parameter int MAX_BOMBS  = 8,
    parameter int POWER_INIT = 1,
    parameter int MAX_POWER  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
    input  logic       done,
    input  logic       pu_bomb,
    input  logic       pu_power,
    input  logic       respawn,
    output logic [3:0] bombs_left,
    output logic [3:0] power
);

    logic [4:0] bomb_sum;
    logic [3:0] bombs_next;
    logic [3:0] power_next;

    // All increments and the decrement are summed first and saturated once,
    // so coincident done + pu_bomb give +2 and ack + done cancel out.
    always_comb begin
        bomb_sum = {1'b0, bombs_left} + {4'd0, done} + {4'd0, pu_bomb};
        if (take) begin
            bomb_sum = bomb_sum - 5'd1;
        end
        bombs_next = (bomb_sum > 5'(MAX_BOMBS)) ? 4'(MAX_BOMBS) : bomb_sum[3:0];
        power_next = (pu_power && (power < 4'(MAX_POWER))) ? power + 4'd1 : power;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bombs_left <= 4'(BOMBS_INIT);
            power      <= 4'(POWER_INIT);
        end else if (respawn) begin
            bombs_left <= 4'(BOMBS_INIT);
            power      <= 4'(POWER_INIT);
        end else begin
            bombs_left <= bombs_next;
            power      <= power_next;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl
// Per-player Bomberman controller: tile-to-tile glides, bomb placement handshake,
// death and timed respawn.
//   frame_clk, Reset_n : frame clock, asynchronous active-low reset
//   command, enabled   : per-frame command; enabled=0 treats it as no_op
//   probe_tx/ty        : tile being checked against the map (combinational)
//   probe_blocked      : map lookup result for the probe tile
//   player_x/y         : pixel position (top-left of the player sprite)
//   tile_x/y           : current tile, updated when a glide completes
//   state, alive       : FSM state and state != DEAD
//   bomb               : bomb placement handshake (master side)
//   bomb_done          : one of this player's bombs exploded
//   pu_bomb, pu_power  : power-up pulses
//   hit                : player is inside a blast
//   bombs_left         : bombs currently available
module player_ctrl
    import bomber_pkg::*;
#(
    parameter int TILE_W         = TILE_W_DEF,
    parameter int TILE_H         = TILE_H_DEF,
    parameter int MAP_W          = MAP_W_DEF,
    parameter int MAP_H          = MAP_H_DEF,
    parameter int X_STEP         = 8,
    parameter int Y_STEP         = 6,
    parameter int INIT_TX        = 1,
    parameter int INIT_TY        = 1,
    parameter int BOMBS_INIT     = 1,
    parameter int MAX_BOMBS      = 8,
    parameter int POWER_INIT     = 1,
    parameter int MAX_POWER      = 7,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  command_t             command,
    input  logic                 enabled,
    output logic [3:0]           probe_tx,
    output logic [3:0]           probe_ty,
    input  logic                 probe_blocked,
    output logic [9:0]           player_x,
    output logic [9:0]           player_y,
    output logic [3:0]           tile_x,
    output logic [3:0]           tile_y,
    output pstate_t              state,
    output logic                 alive,
    player_ctrl_if.master        bomb,
    input  logic                 bomb_done,
    input  logic                 pu_bomb,
    input  logic                 pu_power,
    input  logic                 hit,
    output logic [3:0]           bombs_left
);

    localparam int STEPS_H = TILE_W / X_STEP;
    localparam int STEPS_V = TILE_H / Y_STEP;

    dir_t        dir;
    logic [7:0]  step_cnt;
    logic [3:0]  target_tx;
    logic [3:0]  target_ty;
    logic [15:0] respawn_cnt;
    logic        bomb_req_r;
    logic [3:0]  bomb_tx_r;
    logic [3:0]  bomb_ty_r;
    logic [3:0]  power_latched;
    logic [3:0]  power_cur;

    logic        is_dir;
    logic        out_of_grid;
    logic        move_ok;
    logic        last_step;
    logic        ack_take;
    logic        bomb_accept;
    logic        respawn;

    // Neighbour tile for a direction command. Leaving the grid counts as
    // blocked and the probe then stays on the current tile, which also keeps
    // 0-1 from wrapping around to 15.
    always_comb begin
        is_dir      = (command == CMD_UP) || (command == CMD_DOWN) ||
                      (command == CMD_LEFT) || (command == CMD_RIGHT);
        out_of_grid = 1'b0;
        probe_tx    = tile_x;
        probe_ty    = tile_y;
        case (command)
            CMD_UP: begin
                if (tile_y == 4'd0) out_of_grid = 1'b1;
                else                probe_ty    = tile_y - 4'd1;
            end
            CMD_DOWN: begin
                if (tile_y == 4'(MAP_H - 1)) out_of_grid = 1'b1;
                else                         probe_ty    = tile_y + 4'd1;
            end
            CMD_LEFT: begin
                if (tile_x == 4'd0) out_of_grid = 1'b1;
                else                probe_tx    = tile_x - 4'd1;
            end
            CMD_RIGHT: begin
                if (tile_x == 4'(MAP_W - 1)) out_of_grid = 1'b1;
                else                         probe_tx    = tile_x + 4'd1;
            end
            default: begin
                out_of_grid = 1'b0;
            end
        endcase
    end

    // A coincident hit wins over an ack, so the ack is neither taken nor
    // charged against the inventory in that case.
    assign move_ok     = enabled && is_dir && !out_of_grid && !probe_blocked;
    assign ack_take    = bomb_req_r && bomb.bomb_ack && (state != DEAD) && !hit;
    assign bomb_accept = enabled && (command == CMD_SET_BOMB) && !bomb_req_r &&
                         (bombs_left != 4'd0);
    assign respawn     = (state == DEAD) && (respawn_cnt == 16'd0);
    assign last_step   = ((dir == DIR_LEFT) || (dir == DIR_RIGHT)) ?
                         (step_cnt == 8'(STEPS_H - 1)) : (step_cnt == 8'(STEPS_V - 1));
    assign alive       = (state != DEAD);

    assign bomb.bomb_req   = bomb_req_r;
    assign bomb.bomb_tx    = bomb_tx_r;
    assign bomb.bomb_ty    = bomb_ty_r;
    assign bomb.bomb_power = bomb_req_r ? power_latched : power_cur;

    player_stats #(
        .BOMBS_INIT (BOMBS_INIT),
        .MAX_BOMBS  (MAX_BOMBS),
        .POWER_INIT (POWER_INIT),
        .MAX_POWER  (MAX_POWER)
    ) u_stats (
        .clk        (frame_clk),
        .rst_n      (Reset_n),
        .take       (ack_take),
        .done       (bomb_done),
        .pu_bomb    (pu_bomb && alive),
        .pu_power   (pu_power && alive),
        .respawn    (respawn),
        .bombs_left (bombs_left),
        .power      (power_cur)
    );

    // Player FSM, glide counter and bomb request. The respawn counter is
    // loaded with RESPAWN_FRAMES-1 so the player spends exactly
    // RESPAWN_FRAMES frames in DEAD, including the frame it entered.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            tile_x        <= 4'(INIT_TX);
            tile_y        <= 4'(INIT_TY);
            player_x      <= tile_to_px(4'(INIT_TX), TILE_W);
            player_y      <= tile_to_px(4'(INIT_TY), TILE_H);
            dir           <= DIR_UP;
            step_cnt      <= 8'd0;
            target_tx     <= 4'(INIT_TX);
            target_ty     <= 4'(INIT_TY);
            respawn_cnt   <= 16'd0;
            bomb_req_r    <= 1'b0;
            bomb_tx_r     <= 4'd0;
            bomb_ty_r     <= 4'd0;
            power_latched <= 4'(POWER_INIT);
        end else if ((state != DEAD) && hit) begin
            state       <= DEAD;
            bomb_req_r  <= 1'b0;
            respawn_cnt <= 16'(RESPAWN_FRAMES - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (bomb_accept) begin
                        bomb_req_r    <= 1'b1;
                        bomb_tx_r     <= tile_x;
                        bomb_ty_r     <= tile_y;
                        power_latched <= power_cur;
                    end
                    if (move_ok) begin
                        dir       <= dir_t'(command[1:0]);
                        step_cnt  <= 8'd0;
                        target_tx <= probe_tx;
                        target_ty <= probe_ty;
                        state     <= MOVE;
                    end
                end
                MOVE: begin
                    case (dir)
                        DIR_UP:    player_y <= player_y - 10'(Y_STEP);
                        DIR_DOWN:  player_y <= player_y + 10'(Y_STEP);
                        DIR_LEFT:  player_x <= player_x - 10'(X_STEP);
                        default:   player_x <= player_x + 10'(X_STEP);
                    endcase
                    step_cnt <= step_cnt + 8'd1;
                    if (last_step) begin
                        tile_x <= target_tx;
                        tile_y <= target_ty;
                        state  <= IDLE;
                    end
                end
                DEAD: begin
                    if (respawn_cnt == 16'd0) begin
                        state    <= IDLE;
                        tile_x   <= 4'(INIT_TX);
                        tile_y   <= 4'(INIT_TY);
                        player_x <= tile_to_px(4'(INIT_TX), TILE_W);
                        player_y <= tile_to_px(4'(INIT_TY), TILE_H);
                    end else begin
                        respawn_cnt <= respawn_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (ack_take) begin
                bomb_req_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl
// Directed bench for player_ctrl: glides, blocked probes, bomb handshake,
// saturating counters, death/respawn and reset mid-glide. Expected values
// are queued as stimulus is applied and consumed when outputs are sampled.
module tb_player_ctrl;
    import bomber_pkg::*;

    typedef struct {
        string tag;
        int    value;
    } exp_t;

    logic       frame_clk;
    logic       Reset_n;
    command_t   command;
    logic       enabled;
    logic [3:0] probe_tx;
    logic [3:0] probe_ty;
    logic       probe_blocked;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [3:0] tile_x;
    logic [3:0] tile_y;
    pstate_t    state;
    logic       alive;
    logic       bomb_done;
    logic       pu_bomb;
    logic       pu_power;
    logic       hit;
    logic [3:0] bombs_left;

    player_ctrl_if bomb_bus ();

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   waited;

    player_ctrl dut (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .command       (command),
        .enabled       (enabled),
        .probe_tx      (probe_tx),
        .probe_ty      (probe_ty),
        .probe_blocked (probe_blocked),
        .player_x      (player_x),
        .player_y      (player_y),
        .tile_x        (tile_x),
        .tile_y        (tile_y),
        .state         (state),
        .alive         (alive),
        .bomb          (bomb_bus),
        .bomb_done     (bomb_done),
        .pu_bomb       (pu_bomb),
        .pu_power      (pu_power),
        .hit           (hit),
        .bombs_left    (bombs_left)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input command_t cmd);
        command = cmd;
        tick(1);
        command = CMD_NO_OP;
    endtask

    task automatic expectOut(input string tag, input int value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=none (scoreboard empty)", tag, observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value && tag == e.tag) else begin
                errors++;
                $error("[TB] FAIL %s observed=%0d expected=%0d (queued as %s)", tag, observed, e.value, e.tag);
            end
        end
    endtask

    initial begin
        Reset_n          = 1'b0;
        command          = CMD_NO_OP;
        enabled          = 1'b1;
        probe_blocked    = 1'b0;
        bomb_done        = 1'b0;
        pu_bomb          = 1'b0;
        pu_power         = 1'b0;
        hit              = 1'b0;
        bomb_bus.bomb_ack = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        #1;

        $display("[TB] reset state");
        expectOut("rst_state", 0);  checkOutput("rst_state", state);
        expectOut("rst_x", 64);     checkOutput("rst_x", player_x);
        expectOut("rst_y", 48);     checkOutput("rst_y", player_y);
        expectOut("rst_tile_x", 1); checkOutput("rst_tile_x", tile_x);
        expectOut("rst_tile_y", 1); checkOutput("rst_tile_y", tile_y);
        expectOut("rst_req", 0);    checkOutput("rst_req", bomb_bus.bomb_req);
        expectOut("rst_bombs", 1);  checkOutput("rst_bombs", bombs_left);
        expectOut("rst_power", 1);  checkOutput("rst_power", bomb_bus.bomb_power);
        expectOut("rst_alive", 1);  checkOutput("rst_alive", alive);

        $display("[TB] glide right");
        command = CMD_RIGHT;
        #1;
        expectOut("probe_tx_r", 2); checkOutput("probe_tx_r", probe_tx);
        expectOut("probe_ty_r", 1); checkOutput("probe_ty_r", probe_ty);
        expectOut("move_state", 1);
        expectOut("move_x0", 64);
        for (int i = 1; i <= 8; i++) begin
            expectOut("glide_x", 64 + 8 * i);
            expectOut("glide_state", (i == 8) ? 0 : 1);
            expectOut("glide_tile_x", (i == 8) ? 2 : 1);
        end
        applyStimulus(CMD_RIGHT);
        checkOutput("move_state", state);
        checkOutput("move_x0", player_x);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            checkOutput("glide_x", player_x);
            checkOutput("glide_state", state);
            checkOutput("glide_tile_x", tile_x);
        end

        $display("[TB] blocked left, then back left");
        command       = CMD_LEFT;
        probe_blocked = 1'b1;
        #1;
        expectOut("probe_tx_l", 1); checkOutput("probe_tx_l", probe_tx);
        expectOut("blk_state", 0);
        expectOut("blk_x", 128);
        applyStimulus(CMD_LEFT);
        probe_blocked = 1'b0;
        checkOutput("blk_state", state);
        checkOutput("blk_x", player_x);
        expectOut("left_x", 64);
        expectOut("left_tile_x", 1);
        applyStimulus(CMD_LEFT);
        tick(8);
        checkOutput("left_x", player_x);
        checkOutput("left_tile_x", tile_x);

        $display("[TB] up to row 0, then up out of grid");
        expectOut("up_y", 0);
        expectOut("up_tile_y", 0);
        applyStimulus(CMD_UP);
        tick(8);
        checkOutput("up_y", player_y);
        checkOutput("up_tile_y", tile_y);
        command = CMD_UP;
        #1;
        expectOut("edge_probe_tx", 1); checkOutput("edge_probe_tx", probe_tx);
        expectOut("edge_probe_ty", 0); checkOutput("edge_probe_ty", probe_ty);
        expectOut("edge_state", 0);
        expectOut("edge_y", 0);
        applyStimulus(CMD_UP);
        checkOutput("edge_state", state);
        checkOutput("edge_y", player_y);
        expectOut("down_y", 48);
        expectOut("down_tile_y", 1);
        applyStimulus(CMD_DOWN);
        tick(8);
        checkOutput("down_y", player_y);
        checkOutput("down_tile_y", tile_y);

        $display("[TB] bomb handshake");
        expectOut("req_up", 1);
        expectOut("req_tx", 1);
        expectOut("req_ty", 1);
        expectOut("req_power", 1);
        applyStimulus(CMD_SET_BOMB);
        checkOutput("req_up", bomb_bus.bomb_req);
        checkOutput("req_tx", bomb_bus.bomb_tx);
        checkOutput("req_ty", bomb_bus.bomb_ty);
        checkOutput("req_power", bomb_bus.bomb_power);
        for (int i = 0; i < 3; i++) begin
            expectOut("req_held", 1);
            tick(1);
            checkOutput("req_held", bomb_bus.bomb_req);
        end
        expectOut("ack_req", 0);
        expectOut("ack_bombs", 0);
        bomb_bus.bomb_ack = 1'b1;
        tick(1);
        bomb_bus.bomb_ack = 1'b0;
        checkOutput("ack_req", bomb_bus.bomb_req);
        checkOutput("ack_bombs", bombs_left);
        expectOut("empty_req", 0);
        applyStimulus(CMD_SET_BOMB);
        checkOutput("empty_req", bomb_bus.bomb_req);
        expectOut("done_bombs", 1);
        bomb_done = 1'b1;
        tick(1);
        bomb_done = 1'b0;
        checkOutput("done_bombs", bombs_left);

        $display("[TB] power-ups and saturation");
        expectOut("power_sat", 7);
        pu_power = 1'b1;
        tick(8);
        pu_power = 1'b0;
        checkOutput("power_sat", bomb_bus.bomb_power);
        expectOut("bombs_7", 7);
        pu_bomb = 1'b1;
        tick(6);
        pu_bomb = 1'b0;
        checkOutput("bombs_7", bombs_left);
        expectOut("bombs_pu_done", 8);
        pu_bomb   = 1'b1;
        bomb_done = 1'b1;
        tick(1);
        pu_bomb   = 1'b0;
        bomb_done = 1'b0;
        checkOutput("bombs_pu_done", bombs_left);
        expectOut("bombs_sat", 8);
        pu_bomb = 1'b1;
        tick(1);
        pu_bomb = 1'b0;
        checkOutput("bombs_sat", bombs_left);
        expectOut("req_power7", 7);
        applyStimulus(CMD_SET_BOMB);
        checkOutput("req_power7", bomb_bus.bomb_power);
        expectOut("ackdone_req", 0);
        expectOut("ackdone_bombs", 8);
        bomb_bus.bomb_ack = 1'b1;
        bomb_done         = 1'b1;
        tick(1);
        bomb_bus.bomb_ack = 1'b0;
        bomb_done         = 1'b0;
        checkOutput("ackdone_req", bomb_bus.bomb_req);
        checkOutput("ackdone_bombs", bombs_left);

        $display("[TB] hit mid-glide with request pending");
        expectOut("pre_hit_req", 1);
        applyStimulus(CMD_SET_BOMB);
        checkOutput("pre_hit_req", bomb_bus.bomb_req);
        expectOut("pre_hit_state", 1);
        expectOut("pre_hit_x", 80);
        applyStimulus(CMD_RIGHT);
        tick(2);
        checkOutput("pre_hit_state", state);
        checkOutput("pre_hit_x", player_x);
        expectOut("hit_state", 2);
        expectOut("hit_alive", 0);
        expectOut("hit_req", 0);
        expectOut("hit_x", 80);
        expectOut("hit_bombs", 8);
        hit               = 1'b1;
        bomb_bus.bomb_ack = 1'b1;
        tick(1);
        bomb_bus.bomb_ack = 1'b0;
        checkOutput("hit_state", state);
        checkOutput("hit_alive", alive);
        checkOutput("hit_req", bomb_bus.bomb_req);
        checkOutput("hit_x", player_x);
        checkOutput("hit_bombs", bombs_left);

        expectOut("dead_x_frozen", 80);
        waited = 0;
        while (state != IDLE && waited < 100) begin
            tick(1);
            waited++;
            if (waited == 5) hit = 1'b0;
            if (waited == 10) checkOutput("dead_x_frozen", player_x);
        end
        hit = 1'b0;
        expectOut("respawn_frames", 60); checkOutput("respawn_frames", waited);
        expectOut("spawn_x", 64);        checkOutput("spawn_x", player_x);
        expectOut("spawn_y", 48);        checkOutput("spawn_y", player_y);
        expectOut("spawn_tile_x", 1);    checkOutput("spawn_tile_x", tile_x);
        expectOut("spawn_tile_y", 1);    checkOutput("spawn_tile_y", tile_y);
        expectOut("spawn_bombs", 1);     checkOutput("spawn_bombs", bombs_left);
        expectOut("spawn_power", 1);     checkOutput("spawn_power", bomb_bus.bomb_power);
        expectOut("spawn_alive", 1);     checkOutput("spawn_alive", alive);

        $display("[TB] reset mid-glide and mid-handshake");
        applyStimulus(CMD_SET_BOMB);
        applyStimulus(CMD_RIGHT);
        tick(3);
        expectOut("midrst_pre_x", 88);
        checkOutput("midrst_pre_x", player_x);
        expectOut("midrst_state", 0);
        expectOut("midrst_x", 64);
        expectOut("midrst_y", 48);
        expectOut("midrst_req", 0);
        expectOut("midrst_bombs", 1);
        expectOut("midrst_tile_x", 1);
        Reset_n = 1'b0;
        tick(1);
        checkOutput("midrst_state", state);
        checkOutput("midrst_x", player_x);
        checkOutput("midrst_y", player_y);
        checkOutput("midrst_req", bomb_bus.bomb_req);
        checkOutput("midrst_bombs", bombs_left);
        checkOutput("midrst_tile_x", tile_x);
        Reset_n = 1'b1;
        expectOut("post_rst_state", 0);
        tick(1);
        checkOutput("post_rst_state", state);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
